// File: rtl/board_gpio_bridge.sv
// -----------------------------------------------------------------------------
// board_gpio_bridge
//   Board-side GPIO front end between the board switch/LED pads and the SoC
//   gpioA read / write / writeEnable buses.
//   - Each switch pad is synchronised through SYNC_STAGES flops and then
//     debounced by its own saturating counter.
//   - gpio_read presents the debounced switch state, zero-extended to 32 bits.
//   - sw_change_irq is a sticky flag set by any accepted switch change and
//     cleared by irq_ack. A change wins over a coincident acknowledge.
//   - led_pad is the registered AND of gpio_write and gpio_write_en.
//   Optional feature macro: BOARD_GPIO_LED_PWM_EN
//     When defined, an 8-bit free-running counter dims the LEDs to
//     LED_DUTY/256 on-time. When undefined, LEDs are driven at full brightness.
// -----------------------------------------------------------------------------
module board_gpio_bridge #(
   parameter int          NUM_SW          = 16,
   parameter int          NUM_LED         = 16,
   parameter int          SYNC_STAGES     = 2,
   parameter int          DEBOUNCE_CYCLES = 1000000,
   parameter logic [7:0]  LED_DUTY        = 8'd64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_SW-1:0]   sw_pad,
   output logic [NUM_LED-1:0]  led_pad,
   output logic [31:0]         gpio_read,
   input  logic [31:0]         gpio_write,
   input  logic [31:0]         gpio_write_en,
   output logic                sw_change_irq,
   input  logic                irq_ack
);

   // Counter wide enough to hold DEBOUNCE_CYCLES; it only ever reaches
   // DEBOUNCE_CYCLES-1, where the mismatch is accepted and the count restarts.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][NUM_SW-1:0] sync_r;
   logic [NUM_SW-1:0]                  sw_sync_s;
   logic [NUM_SW-1:0]                  stable_s;
   logic [NUM_SW-1:0]                  accept_s;
   logic                               change_r;
   logic                               irq_r;
   logic [NUM_LED-1:0]                 led_on_s;
   logic [NUM_LED-1:0]                 led_r;

   // Synchroniser chain: stage 0 samples the raw pads, the last stage feeds debounce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], sw_pad};
      end
   end

   assign sw_sync_s = sync_r[SYNC_STAGES-1];

   // Per-channel debounce: each switch owns an independent counter and stable bit.
   for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
      logic [CNT_W-1:0] cnt_r;
      logic             stable_bit_r;
      logic             mismatch_s;
      logic             expire_s;

      // Mismatch against the accepted level, and whether this cycle completes the window.
      always_comb begin
         mismatch_s = sw_sync_s[i] ^ stable_bit_r;
         expire_s   = mismatch_s & (cnt_r == CNT_LAST);
      end

      // Count consecutive mismatch cycles; any agreement discards the partial count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_r        <= '0;
            stable_bit_r <= 1'b0;
         end else if (!mismatch_s) begin
            cnt_r        <= '0;
         end else if (expire_s) begin
            cnt_r        <= '0;
            stable_bit_r <= sw_sync_s[i];
         end else begin
            cnt_r        <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end

      assign stable_s[i] = stable_bit_r;
      assign accept_s[i] = expire_s;
   end

   // Registered change pulse: one pulse no matter how many channels flip together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         change_r <= 1'b0;
      end else begin
         change_r <= |accept_s;
      end
   end

   // Sticky interrupt flag: a change pulse has priority over a simultaneous acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_r <= 1'b0;
      end else if (change_r) begin
         irq_r <= 1'b1;
      end else if (irq_ack) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= irq_r;
      end
   end

   // Read bus: debounced switches in the low bits, unused channels read as zero.
   always_comb begin
      gpio_read                = 32'd0;
      gpio_read[NUM_SW-1:0]    = stable_s;
   end

   // LED request: only bits the SoC both writes and enables light up.
   always_comb begin
      led_on_s = gpio_write[NUM_LED-1:0] & gpio_write_en[NUM_LED-1:0];
   end

`ifdef BOARD_GPIO_LED_PWM_EN
   logic [7:0] pwm_cnt_r;
   logic       pwm_on_s;

   // Free-running PWM phase counter; wraps 255 -> 0 for a 256-cycle period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_r <= 8'd0;
      end else begin
         pwm_cnt_r <= pwm_cnt_r + 8'd1;
      end
   end

   // On-phase of the PWM period; LED_DUTY of zero keeps the LEDs dark.
   always_comb begin
      pwm_on_s = (pwm_cnt_r < LED_DUTY);
   end

   // Registered LED drive gated by the PWM on-phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_r <= '0;
      end else begin
         led_r <= led_on_s & {NUM_LED{pwm_on_s}};
      end
   end
`else
   // Registered LED drive at full brightness.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_r <= '0;
      end else begin
         led_r <= led_on_s;
      end
   end
`endif

   assign led_pad       = led_r;
   assign sw_change_irq = irq_r;

endmodule
